// File: rtl/seq_pattern_gen_1010_if.sv
// Handshake and serial-output bundle for the 1010 pattern transmitter.
// The Pat load bus exists only when PAT_LOAD_EN is defined.
interface seq_pattern_gen_1010_if #(
    parameter int CNT_W = 4
`ifdef PAT_LOAD_EN
    , parameter int PAT_W = 4
`endif
);
    logic             Start;
    logic             Stop;
    logic [CNT_W-1:0] Rep;
`ifdef PAT_LOAD_EN
    logic [PAT_W-1:0] Pat;
`endif
    logic             Out;
    logic             Valid;
    logic             Busy;
    logic             Done;
    logic [2:0]       sta;

`ifdef PAT_LOAD_EN
    modport master (output Start, Stop, Rep, Pat, input Out, Valid, Busy, Done, sta);
    modport slave  (input Start, Stop, Rep, Pat, output Out, Valid, Busy, Done, sta);
`else
    modport master (output Start, Stop, Rep, input Out, Valid, Busy, Done, sta);
    modport slave  (input Start, Stop, Rep, output Out, Valid, Busy, Done, sta);
`endif
endinterface

// File: rtl/seq_pattern_gen_1010.sv
// Serial pattern transmitter: emits a PAT_W-bit pattern MSB-first, Rep times, with GAP_CYC idle cycles between.
// Optional macro PAT_LOAD_EN: pattern is loaded from bus.Pat on an accepted Start instead of the constant PATTERN.
module seq_pattern_gen_1010 #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1010),
    parameter int             CNT_W   = 4,
    parameter int             GAP_CYC = 1
) (
    input logic                  Clk,
    input logic                  Rst,
    seq_pattern_gen_1010_if.slave bus
);
    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] rep_cnt;
    logic [BIT_W-1:0] bit_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [PAT_W-1:0] pat_burst;
    logic [PAT_W-1:0] pat_start;

`ifdef PAT_LOAD_EN
    logic [PAT_W-1:0] pat_reg;
    assign pat_burst = pat_reg;
    assign pat_start = bus.Pat;
`else
    assign pat_burst = PATTERN;
    assign pat_start = PATTERN;
`endif

    assign bus.sta = state;

    // Outputs are registered alongside the state, so each branch sets the values for the state it enters.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            rep_cnt   <= '0;
            bit_idx   <= '0;
            gap_cnt   <= '0;
            bus.Out   <= 1'b0;
            bus.Valid <= 1'b0;
            bus.Busy  <= 1'b0;
            bus.Done  <= 1'b0;
`ifdef PAT_LOAD_EN
            pat_reg   <= PATTERN;
`endif
        end else begin
            bus.Out   <= 1'b0;
            bus.Valid <= 1'b0;
            bus.Done  <= 1'b0;
            bus.Busy  <= 1'b1;
            case (state)
                IDLE: begin
                    bus.Busy <= 1'b0;
                    if (bus.Start && !bus.Stop) begin
                        bus.Busy <= 1'b1;
                        if (bus.Rep == '0) begin
                            state    <= DONE;
                            bus.Done <= 1'b1;
                        end else begin
                            state     <= SHIFT;
                            rep_cnt   <= bus.Rep;
                            bit_idx   <= BIT_LAST;
                            bus.Out   <= pat_start[PAT_W-1];
                            bus.Valid <= 1'b1;
`ifdef PAT_LOAD_EN
                            pat_reg   <= bus.Pat;
`endif
                        end
                    end
                end
                SHIFT: begin
                    if (bus.Stop) begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                    end else if (bit_idx == '0) begin
                        rep_cnt <= rep_cnt - 1'b1;
                        if (rep_cnt == CNT_W'(1)) begin
                            state    <= DONE;
                            bus.Done <= 1'b1;
                        end else if (GAP_CYC > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LAST;
                        end else begin
                            bit_idx   <= BIT_LAST;
                            bus.Out   <= pat_burst[PAT_W-1];
                            bus.Valid <= 1'b1;
                        end
                    end else begin
                        bit_idx   <= bit_idx - 1'b1;
                        bus.Out   <= pat_burst[bit_idx - 1'b1];
                        bus.Valid <= 1'b1;
                    end
                end
                GAP: begin
                    if (bus.Stop) begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state     <= SHIFT;
                        bit_idx   <= BIT_LAST;
                        bus.Out   <= pat_burst[PAT_W-1];
                        bus.Valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen_1010.sv
// Self-checking bench for seq_pattern_gen_1010: expected serial streams are expanded from the burst rules.
module tb_seq_pattern_gen_1010;
    localparam int         PAT_W   = 4;
    localparam int         CNT_W   = 4;
    localparam int         GAP     = 1;
    localparam logic [3:0] PATTERN = 4'b1010;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   det_count;
    int   det_bits;
    logic [3:0] det_win;
    logic [3:0] cur_pat = PATTERN;

    always #5 Clk = ~Clk;

`ifdef PAT_LOAD_EN
    seq_pattern_gen_1010_if #(.CNT_W(CNT_W), .PAT_W(PAT_W)) bus ();
`else
    seq_pattern_gen_1010_if #(.CNT_W(CNT_W)) bus ();
`endif

    seq_pattern_gen_1010 #(
        .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W), .GAP_CYC(GAP)
    ) dut (
        .Clk(Clk), .Rst(Rst), .bus(bus)
    );

    function automatic logic [6:0] obs();
        return {bus.Out, bus.Valid, bus.Busy, bus.Done, bus.sta};
    endfunction

    task automatic start_burst(input int rep);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Stop  = 1'b0;
        bus.Rep   = rep[CNT_W-1:0];
`ifdef PAT_LOAD_EN
        bus.Pat   = cur_pat;
`endif
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Rep   = CNT_W'($urandom);
`ifdef PAT_LOAD_EN
        bus.Pat   = 4'($urandom);
`endif
    endtask

    // Expected per-cycle {Out,Valid,Busy,Done,sta} for the cycles following an accepted Start edge.
    task automatic check_stream(input string name, input int rep, input bit tail_idle, input int ncyc);
        logic [6:0] q[$];
        logic [6:0] got;
        for (int r = 0; r < rep; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) q.push_back({cur_pat[b], 1'b1, 1'b1, 1'b0, 3'd1});
            if (r < rep - 1)
                for (int g = 0; g < GAP; g++) q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 3'd2});
        end
        q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 3'd3});
        if (tail_idle) q.push_back(7'd0);
        det_count = 0;
        det_bits  = 0;
        det_win   = 4'd0;
        for (int i = 0; i < q.size(); i++) begin
            if (ncyc >= 0 && i >= ncyc) break;
            @(negedge Clk);
            got = obs();
            checks++;
            if (got !== q[i]) begin
                failures++;
                $display("FAIL %s cycle %0d: got {Out,Valid,Busy,Done,sta}=%b required %b", name, i + 1, got, q[i]);
            end
            if (bus.Valid === 1'b1) begin
                det_win = {det_win[2:0], bus.Out};
                det_bits++;
                if (det_bits >= 4 && det_win == 4'b1010) begin
                    det_count++;
                    det_bits = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        bus.Rep   = '0;
`ifdef PAT_LOAD_EN
        bus.Pat   = '0;
`endif
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (obs() !== 7'd0) begin
            failures++;
            $display("FAIL reset_hold: got %b required %b", obs(), 7'd0);
        end
        Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if (obs() !== 7'd0) begin
            failures++;
            $display("FAIL reset_release: got %b required %b", obs(), 7'd0);
        end
    endtask

    task automatic test_single();
        start_burst(1);
        check_stream("single", 1, 1'b1, -1);
    endtask

    task automatic test_rep_gap();
        start_burst(3);
        check_stream("rep3", 3, 1'b1, -1);
        checks++;
        if (det_count !== 3) begin
            failures++;
            $display("FAIL rep3_detect: got %0d detections required %0d", det_count, 3);
        end
    endtask

    task automatic test_rep_zero();
        start_burst(0);
        check_stream("rep0", 0, 1'b1, -1);
    endtask

    task automatic test_stop();
        start_burst(2);
        check_stream("stop_pre", 2, 1'b0, 8);
        bus.Stop = 1'b1;
        @(posedge Clk);
        #1 bus.Stop = 1'b0;
        @(negedge Clk);
        checks++;
        if (obs() !== 7'd0) begin
            failures++;
            $display("FAIL stop_abort: got %b required %b", obs(), 7'd0);
        end
        bus.Start = 1'b1;
        bus.Rep   = 4'd1;
`ifdef PAT_LOAD_EN
        bus.Pat   = cur_pat;
`endif
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        check_stream("stop_restart", 1, 1'b1, -1);
    endtask

    task automatic test_start_held();
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Rep   = 4'd2;
`ifdef PAT_LOAD_EN
        bus.Pat   = cur_pat;
`endif
        @(posedge Clk);
        #1 bus.Rep = 4'd5;
        check_stream("held_first", 2, 1'b0, -1);
        @(negedge Clk);
        checks++;
        if (obs() !== 7'd0) begin
            failures++;
            $display("FAIL held_idle: got %b required %b", obs(), 7'd0);
        end
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Rep   = CNT_W'($urandom);
        check_stream("held_second", 5, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        start_burst(3);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1 Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if (obs() !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid: got %b required %b", obs(), 7'd0);
        end
    endtask

    task automatic test_start_stop();
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        bus.Rep   = CNT_W'($urandom_range(1, 15));
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (obs() !== 7'd0) begin
                failures++;
                $display("FAIL start_stop: got %b required %b", obs(), 7'd0);
            end
        end
    endtask

    task automatic test_random();
        int rep;
        for (int n = 0; n < 10; n++) begin
            rep = $urandom_range(0, 15);
`ifdef PAT_LOAD_EN
            cur_pat = 4'($urandom);
`endif
            start_burst(rep);
            check_stream("random", rep, 1'b1, -1);
        end
    endtask

`ifdef PAT_LOAD_EN
    task automatic test_pat_load();
        cur_pat = 4'b1100;
        start_burst(2);
        check_stream("pat_load", 2, 1'b1, -1);
        cur_pat = PATTERN;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rep_gap();
        test_rep_zero();
        test_stop();
        test_start_held();
        test_reset_mid();
        test_start_stop();
`ifdef PAT_LOAD_EN
        test_pat_load();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
